// File: rtl/mips32_insn_loader.sv
// Encodes symbolic MIPS32 instructions (ADD..J) and writes them sequentially
// into instruction memory through a single write port.
module mips32_insn_loader #(
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0,
  parameter int DEPTH     = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              inValid,
  output logic              inReady,
  input  logic [3:0]        inOp,
  input  logic [4:0]        inRs,
  input  logic [4:0]        inRt,
  input  logic [4:0]        inRd,
  input  logic [15:0]       inImm,
  input  logic [25:0]       inTarget,
  input  logic              finish,
  output logic              memWrite,
  output logic [ADDR_W-1:0] memAddr,
  output logic [31:0]       memWData,
  output logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              done,
  output logic              full,
  output logic              invOp
);

  typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;

  state_t            state;
  logic              finLatched;
  logic              opValid;
  logic              accept;
  logic [31:0]       encWord;
  logic [ADDR_W:0]   countNext;

  assign inReady   = (state == LOAD) && !full;
  assign accept    = inValid && inReady;
  assign countNext = count + (ADDR_W+1)'(1);

  always_comb begin
    encWord = '0;
    opValid = 1'b1;
    case (inOp)
      4'd0:    encWord = {6'h00, inRs, inRt, inRd, 5'd0, 6'h20};
      4'd1:    encWord = {6'h00, inRs, inRt, inRd, 5'd0, 6'h22};
      4'd2:    encWord = {6'h00, inRs, inRt, inRd, 5'd0, 6'h24};
      4'd3:    encWord = {6'h00, inRs, inRt, inRd, 5'd0, 6'h25};
      4'd4:    encWord = {6'h00, inRs, inRt, inRd, 5'd0, 6'h2A};
      4'd5:    encWord = {6'h23, inRs, inRt, inImm};
      4'd6:    encWord = {6'h2B, inRs, inRt, inImm};
      4'd7:    encWord = {6'h04, inRs, inRt, inImm};
      4'd8:    encWord = {6'h05, inRs, inRt, inImm};
      4'd9:    encWord = {6'h02, inTarget};
      default: opValid = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      finLatched <= 1'b0;
      memWrite   <= 1'b0;
      memAddr    <= '0;
      memWData   <= '0;
      count      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      full       <= 1'b0;
      invOp      <= 1'b0;
    end else if (start) begin
      // restart drops any in-flight write; memAddr/memWData keep last values
      state      <= LOAD;
      finLatched <= 1'b0;
      memWrite   <= 1'b0;
      count      <= '0;
      busy       <= 1'b1;
      done       <= 1'b0;
      full       <= 1'b0;
      invOp      <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          if (accept && opValid) begin
            memWData   <= encWord;
            memAddr    <= ADDR_W'(BASE_ADDR) + count[ADDR_W-1:0];
            memWrite   <= 1'b1;
            finLatched <= finish;
            state      <= WRITE;
          end else begin
            if (accept) invOp <= 1'b1;
            if (finish) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        WRITE: begin
          memWrite <= 1'b0;
          count    <= countNext;
          full     <= (countNext == (ADDR_W+1)'(DEPTH));
          if (finLatched || finish) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state <= LOAD;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips32_insn_loader.sv
// Scoreboard bench for mips32_insn_loader: a default instance (A) and a
// DEPTH=4 instance based near the top of the address space (B).
module tb_mips32_insn_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        startA = 1'b0, startB = 1'b0;
  logic        inValid = 1'b0, finish = 1'b0;
  logic [3:0]  inOp = '0;
  logic [4:0]  inRs = '0, inRt = '0, inRd = '0;
  logic [15:0] inImm = '0;
  logic [25:0] inTarget = '0;

  logic        inReadyA, memWriteA, busyA, doneA, fullA, invOpA;
  logic [9:0]  memAddrA;
  logic [31:0] memWDataA;
  logic [10:0] countA;
  logic        inReadyB, memWriteB, busyB, doneB, fullB, invOpB;
  logic [9:0]  memAddrB;
  logic [31:0] memWDataB;
  logic [10:0] countB;

  int passCnt = 0, totalCnt = 0, cyc = 0;
  logic [41:0] qA[$], qB[$];
  logic prevWrA = 1'b0, prevWrB = 1'b0;

  mips32_insn_loader #(.ADDR_W(10), .BASE_ADDR(0), .DEPTH(1024)) dutA (
    .clk(clk), .rst(rst), .start(startA), .inValid(inValid), .inReady(inReadyA),
    .inOp(inOp), .inRs(inRs), .inRt(inRt), .inRd(inRd), .inImm(inImm),
    .inTarget(inTarget), .finish(finish), .memWrite(memWriteA), .memAddr(memAddrA),
    .memWData(memWDataA), .count(countA), .busy(busyA), .done(doneA),
    .full(fullA), .invOp(invOpA));

  mips32_insn_loader #(.ADDR_W(10), .BASE_ADDR(1022), .DEPTH(4)) dutB (
    .clk(clk), .rst(rst), .start(startB), .inValid(inValid), .inReady(inReadyB),
    .inOp(inOp), .inRs(inRs), .inRt(inRt), .inRd(inRd), .inImm(inImm),
    .inTarget(inTarget), .finish(finish), .memWrite(memWriteB), .memAddr(memAddrB),
    .memWData(memWDataB), .count(countB), .busy(busyB), .done(doneB),
    .full(fullB), .invOp(invOpB));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    logic [41:0] e;
    if (memWriteA) begin
      totalCnt++;
      if (qA.size() == 0)
        $display("FAIL writeA unexpected: addr=%0d data=%h", memAddrA, memWDataA);
      else begin
        e = qA.pop_front();
        if ({memAddrA, memWDataA} !== e)
          $display("FAIL writeA: got addr=%0d data=%h, want addr=%0d data=%h",
                   memAddrA, memWDataA, e[41:32], e[31:0]);
        else passCnt++;
      end
      totalCnt++;
      if (prevWrA) $display("FAIL pulseA: memWrite high 2 cycles, want 1");
      else passCnt++;
    end
    prevWrA = memWriteA;
  end

  always @(negedge clk) begin
    logic [41:0] e;
    if (memWriteB) begin
      totalCnt++;
      if (qB.size() == 0)
        $display("FAIL writeB unexpected: addr=%0d data=%h", memAddrB, memWDataB);
      else begin
        e = qB.pop_front();
        if ({memAddrB, memWDataB} !== e)
          $display("FAIL writeB: got addr=%0d data=%h, want addr=%0d data=%h",
                   memAddrB, memWDataB, e[41:32], e[31:0]);
        else passCnt++;
      end
      totalCnt++;
      if (prevWrB) $display("FAIL pulseB: memWrite high 2 cycles, want 1");
      else passCnt++;
    end
    prevWrB = memWriteB;
  end

  function automatic logic [31:0] expWord(input logic [3:0] op, input logic [4:0] rs,
      input logic [4:0] rt, input logic [4:0] rd, input logic [15:0] imm,
      input logic [25:0] tgt);
    logic [31:0] f, o;
    f = 0; o = 0;
    case (op)
      0: f = 32; 1: f = 34; 2: f = 36; 3: f = 37; 4: f = 42;
      5: o = 35; 6: o = 43; 7: o = 4;  8: o = 5;
      default: ;
    endcase
    if (op <= 4) return (32'(rs) << 21) | (32'(rt) << 16) | (32'(rd) << 11) | f;
    if (op == 9) return (32'd2 << 26) | 32'(tgt);
    return (o << 26) | (32'(rs) << 21) | (32'(rt) << 16) | 32'(imm);
  endfunction

  task automatic pulseStart(input bit sel);
    @(posedge clk); #1;
    if (sel) startB = 1'b1; else startA = 1'b1;
    @(posedge clk); #1;
    startA = 1'b0; startB = 1'b0;
  endtask

  task automatic doBeat(input bit sel, input logic [3:0] op, input logic [4:0] rs,
      input logic [4:0] rt, input logic [4:0] rd, input logic [15:0] imm,
      input logic [25:0] tgt, output int acc);
    inOp = op; inRs = rs; inRt = rt; inRd = rd; inImm = imm; inTarget = tgt;
    inValid = 1'b1;
    acc = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if ((sel ? inReadyB : inReadyA) === 1'b1) begin
        @(posedge clk); #1;
        acc = cyc;
        return;
      end
    end
    totalCnt++;
    $display("FAIL accept_timeout: op=%0d not accepted in 20 cycles", op);
  endtask

  task automatic waitCycles(input int n);
    for (int i = 0; i < n; i++) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #2;
    totalCnt++;
    if ({inReadyA, memWriteA, memAddrA, memWDataA, countA, busyA, doneA, fullA, invOpA} !== '0)
      $display("FAIL resetA: got %h, want 0",
               {inReadyA, memWriteA, memAddrA, memWDataA, countA, busyA, doneA, fullA, invOpA});
    else passCnt++;
    totalCnt++;
    if ({inReadyB, memWriteB, memAddrB, memWDataB, countB, busyB, doneB, fullB, invOpB} !== '0)
      $display("FAIL resetB: got %h, want 0",
               {inReadyB, memWriteB, memAddrB, memWDataB, countB, busyB, doneB, fullB, invOpB});
    else passCnt++;
    #10 rst = 1'b0;
  endtask

  task automatic test_add;
    int acc;
    pulseStart(0);
    totalCnt++;
    if (busyA !== 1'b1 || inReadyA !== 1'b1) $display("FAIL add_load: busy=%b inReady=%b, want 1 1", busyA, inReadyA);
    else passCnt++;
    qA.push_back({10'd0, 32'h00221820});
    doBeat(0, 4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, acc);
    inValid = 1'b0;
    totalCnt++;
    if (inReadyA !== 1'b0) $display("FAIL add_ready_in_write: got %b, want 0", inReadyA);
    else passCnt++;
    waitCycles(1);
    totalCnt++;
    if (countA !== 11'd1) $display("FAIL add_count: got %0d, want 1", countA);
    else passCnt++;
  endtask

  task automatic test_back_to_back;
    logic [3:0]  ops[5]  = '{4'd1, 4'd5, 4'd6, 4'd7, 4'd9};
    logic [4:0]  rss[5]  = '{5'd6, 5'd29, 5'd29, 5'd1, 5'd0};
    logic [4:0]  rts[5]  = '{5'd7, 5'd8, 5'd9, 5'd2, 5'd0};
    logic [4:0]  rds[5]  = '{5'd5, 5'd0, 5'd0, 5'd0, 5'd0};
    logic [15:0] imms[5] = '{16'h0, 16'h4, 16'h8, 16'hFFFF, 16'h0};
    logic [31:0] words[5] = '{32'h00C72822, 32'h8FA80004, 32'hAFA90008, 32'h1022FFFF, 32'h08100000};
    int acc, prevAcc;
    pulseStart(0);
    prevAcc = 0;
    for (int i = 0; i < 5; i++) begin
      qA.push_back({10'(i), words[i]});
      doBeat(0, ops[i], rss[i], rts[i], rds[i], imms[i], (i == 4) ? 26'h0100000 : 26'h0, acc);
      if (i > 0) begin
        totalCnt++;
        if (acc - prevAcc !== 2) $display("FAIL b2b_spacing[%0d]: got %0d cycles, want 2", i, acc - prevAcc);
        else passCnt++;
      end
      prevAcc = acc;
    end
    inValid = 1'b0;
    waitCycles(2);
    totalCnt++;
    if (countA !== 11'd5) $display("FAIL b2b_count: got %0d, want 5", countA);
    else passCnt++;
  endtask

  task automatic test_invalid_op;
    int acc;
    doBeat(0, 4'd12, 5'd1, 5'd1, 5'd1, 16'h0, 26'h0, acc);
    inValid = 1'b0;
    totalCnt++;
    if (invOpA !== 1'b1 || memWriteA !== 1'b0) $display("FAIL inv_flag: invOp=%b memWrite=%b, want 1 0", invOpA, memWriteA);
    else passCnt++;
    waitCycles(2);
    totalCnt++;
    if (countA !== 11'd5 || inReadyA !== 1'b1) $display("FAIL inv_count: count=%0d inReady=%b, want 5 1", countA, inReadyA);
    else passCnt++;
    qA.push_back({10'd5, expWord(4'd3, 5'd10, 5'd11, 5'd12, 16'h0, 26'h0)});
    doBeat(0, 4'd3, 5'd10, 5'd11, 5'd12, 16'h1234, 26'h0, acc);
    inValid = 1'b0;
    waitCycles(1);
    totalCnt++;
    if (countA !== 11'd6 || invOpA !== 1'b1) $display("FAIL inv_or: count=%0d invOp=%b, want 6 1", countA, invOpA);
    else passCnt++;
  endtask

  task automatic test_finish_same;
    int acc;
    pulseStart(0);
    doBeat(0, 4'd15, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0, acc);
    qA.push_back({10'd0, expWord(4'd4, 5'd4, 5'd5, 5'd6, 16'h0, 26'h0)});
    finish = 1'b1;
    doBeat(0, 4'd4, 5'd4, 5'd5, 5'd6, 16'h0, 26'h0, acc);
    finish = 1'b0;
    inValid = 1'b0;
    @(negedge clk);
    totalCnt++;
    if (doneA !== 1'b0 || busyA !== 1'b1) $display("FAIL fin_write: done=%b busy=%b, want 0 1", doneA, busyA);
    else passCnt++;
    waitCycles(1);
    totalCnt++;
    if (doneA !== 1'b1 || busyA !== 1'b0 || countA !== 11'd1 || invOpA !== 1'b1)
      $display("FAIL fin_done: done=%b busy=%b count=%0d invOp=%b, want 1 0 1 1", doneA, busyA, countA, invOpA);
    else passCnt++;
    inValid = 1'b1;
    waitCycles(3);
    inValid = 1'b0;
    totalCnt++;
    if (inReadyA !== 1'b0 || countA !== 11'd1) $display("FAIL fin_ignore: inReady=%b count=%0d, want 0 1", inReadyA, countA);
    else passCnt++;
  endtask

  task automatic test_full;
    int acc;
    bit readySeen;
    logic [3:0] ops[4] = '{4'd2, 4'd8, 4'd0, 4'd6};
    logic [9:0] addrs[4] = '{10'd1022, 10'd1023, 10'd0, 10'd1};
    pulseStart(1);
    for (int i = 0; i < 4; i++) begin
      qB.push_back({addrs[i], expWord(ops[i], 5'(i + 1), 5'(i + 2), 5'(i + 3), 16'(16'hA000 + i), 26'h0)});
      doBeat(1, ops[i], 5'(i + 1), 5'(i + 2), 5'(i + 3), 16'(16'hA000 + i), 26'h0, acc);
    end
    inOp = 4'd1;
    readySeen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i > 0 && inReadyB !== 1'b0) readySeen = 1'b1;
    end
    totalCnt++;
    if (readySeen) $display("FAIL full_ready: inReady rose while full, want 0");
    else passCnt++;
    totalCnt++;
    if (fullB !== 1'b1 || countB !== 11'd4) $display("FAIL full_flag: full=%b count=%0d, want 1 4", fullB, countB);
    else passCnt++;
    @(posedge clk); #1;
    inValid = 1'b0;
    finish = 1'b1;
    waitCycles(1);
    finish = 1'b0;
    totalCnt++;
    if (doneB !== 1'b1 || busyB !== 1'b0) $display("FAIL full_finish: done=%b busy=%b, want 1 0", doneB, busyB);
    else passCnt++;
  endtask

  task automatic test_restart;
    int acc;
    pulseStart(0);
    totalCnt++;
    if (doneA !== 1'b0 || invOpA !== 1'b0 || countA !== '0 || busyA !== 1'b1)
      $display("FAIL restart_clear: done=%b invOp=%b count=%0d busy=%b, want 0 0 0 1", doneA, invOpA, countA, busyA);
    else passCnt++;
    qA.push_back({10'd0, expWord(4'd0, 5'd31, 5'd30, 5'd29, 16'h0, 26'h0)});
    doBeat(0, 4'd0, 5'd31, 5'd30, 5'd29, 16'h0, 26'h0, acc);
    inValid = 1'b0;
    waitCycles(1);
    totalCnt++;
    if (countA !== 11'd1) $display("FAIL restart_count: got %0d, want 1", countA);
    else passCnt++;
  endtask

  task automatic test_rst_mid_write;
    int acc;
    doBeat(0, 4'd5, 5'd2, 5'd3, 5'd0, 16'h10, 26'h0, acc);
    inValid = 1'b0;
    totalCnt++;
    if (memWriteA !== 1'b1) $display("FAIL rst_pre: memWrite=%b, want 1", memWriteA);
    else passCnt++;
    rst = 1'b1;
    #1;
    totalCnt++;
    if ({inReadyA, memWriteA, memAddrA, memWDataA, countA, busyA, doneA, fullA, invOpA} !== '0)
      $display("FAIL rst_mid: got %h, want 0",
               {inReadyA, memWriteA, memAddrA, memWDataA, countA, busyA, doneA, fullA, invOpA});
    else passCnt++;
    totalCnt++;
    if ({doneB, busyB, countB} !== '0) $display("FAIL rst_midB: got %h, want 0", {doneB, busyB, countB});
    else passCnt++;
    #12 rst = 1'b0;
    waitCycles(3);
    totalCnt++;
    if (busyA !== 1'b0 || countA !== '0 || inReadyA !== 1'b0)
      $display("FAIL rst_idle: busy=%b count=%0d inReady=%b, want 0 0 0", busyA, countA, inReadyA);
    else passCnt++;
  endtask

  initial begin
    test_reset;
    test_add;
    test_back_to_back;
    test_invalid_op;
    test_finish_same;
    test_full;
    test_restart;
    test_rst_mid_write;
    waitCycles(2);
    totalCnt++;
    if (qA.size() != 0 || qB.size() != 0)
      $display("FAIL scoreboard_drain: pending A=%0d B=%0d, want 0 0", qA.size(), qB.size());
    else passCnt++;
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule

// File: doc/mips32_insn_loader.md
# mips32_insn_loader

Instruction encoder/loader for the MIPS32 SOC: the encoding counterpart of the control unit's decoder. It accepts symbolic instructions (operation code plus register/immediate/target fields) over a valid/ready handshake and encodes them into 32-bit MIPS32 machine words. It writes each word sequentially into instruction memory through a single write port. It is used at boot and by testbenches to fill instruction memory before the core runs, and it covers exactly the set the control unit decodes: ADD, SUB, AND, OR, SLT, LW, SW, BEQ, BNE, J.

## Interface
- ADDR_W, 10, instruction-memory word-address width
- BASE_ADDR, 0, word address of the first write
- DEPTH, 1024, maximum words written per load session (DEPTH ≤ 2^ADDR_W)

- clk  in  1  clock; all state on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin or restart a session
- inValid  in  1  instruction beat valid
- inReady  out  1  loader can accept a beat
- inOp  in  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT, 5 LW, 6 SW, 7 BEQ, 8 BNE, 9 J; 10-15 invalid
- inRs, inRt, inRd  in  5 each  register fields
- inImm  in  16  immediate/offset, passed through unmodified
- inTarget  in  26  jump target field
- finish  in  1  end the session
- memWrite  out  1  instruction-memory write strobe
- memAddr  out  ADDR_W  write word address
- memWData  out  32  encoded word
- count  out  ADDR_W+1  words written this session
- busy  out  1  session active (LOAD or WRITE)
- done  out  1  session finished (level)
- full  out  1  count == DEPTH
- invOp  out  1  sticky: an invalid inOp was offered

## Operation
- States: IDLE, LOAD, WRITE, DONE.
- Reset: state IDLE. All outputs 0: inReady, memWrite, memAddr, memWData, count, busy, done, full, invOp.
- start has top priority in every state. It clears count, invOp, done and any latched finish, then enters LOAD. A pending WRITE is dropped and memWrite is not asserted.
- IDLE/DONE: inReady=0. Beats and finish are ignored.
- LOAD:
  - inReady = !full.
  - On inValid && inReady with a valid inOp, the encoded word and address are registered and the state moves to WRITE.
  - With an invalid inOp, the beat is consumed, invOp is set, nothing is written, and the state stays LOAD.
- WRITE: memWrite=1 for exactly one cycle with memAddr = (BASE_ADDR + count) mod 2^ADDR_W. count increments on the same edge. Then the state goes to DONE if finish is latched, else LOAD. inReady=0.
- finish:
  - In LOAD with no accepted beat: go to DONE.
  - With a beat accepted on the same cycle: the beat wins, finish is latched, and the state reaches DONE after the WRITE.
  - In WRITE: latched.
- full: when count reaches DEPTH, inReady stays 0. finish is still honoured.
- Encoding (bit fields):
  - R-type: opc[31:26]=0, rs[25:21], rt[20:16], rd[15:11], shamt[10:6]=0, func[5:0]. func is ADD 0x20, SUB 0x22, AND 0x24, OR 0x25, SLT 0x2A.
  - I-type: opc, rs, rt, imm[15:0]. opc is LW 0x23, SW 0x2B, BEQ 0x04, BNE 0x05.
  - J: opc 0x02, target[25:0].
  - Fields not used by an operation (e.g. inRd for LW) are ignored.
- memAddr/memWData hold their last values outside WRITE.

## Timing
- Accept edge N → memWrite high during cycle N+1 → inReady may rise again in cycle N+2. Throughput is 1 word per 2 cycles.
- busy = state ∈ {LOAD, WRITE}. done = state == DONE. Both are registered, with no combinational path from inputs.
- inReady is combinational from state and full only, never from inValid.
- A source must hold a beat stable until inValid && inReady.
- rst asserted mid-session returns to IDLE immediately. No write completes after rst asserts.

## Test plan
- start, ADD rs=1 rt=2 rd=3 → memWrite one cycle, memAddr=0, memWData=0x00221820, count=1.
- Back-to-back SUB rd=5 rs=6 rt=7, LW rt=8 rs=29 imm=4, SW rt=9 rs=29 imm=8, BEQ rs=1 rt=2 imm=0xFFFF, J target=0x0100000, with inValid held high → words 0x00C72822, 0x8FA80004, 0xAFA90008, 0x1022FFFF, 0x08100000 at addresses 0-4. Exactly one accept every 2 cycles.
- inOp=12 offered → invOp=1, no memWrite, count unchanged. A following OR beat is still written.
- DEPTH=4: four writes → full=1 and inReady stays 0 with inValid held. finish → done=1, busy=0.
- finish on the same cycle as an accepted SLT beat → SLT word written, then done=1. A new start clears done, invOp and count, and the next write goes to BASE_ADDR.
- rst asserted during WRITE → memWrite low immediately, all outputs 0, state IDLE.
